// File: rtl/load_store_buffer_pkg.sv
// Shared definitions for the load/store buffer: RISC-V encodings, memory size
// codes, ROB tag conventions, the queue entry payload and the control states.
package load_store_buffer_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned ROB_TAG_W = 5;

  // Tag 0 is reserved to mean "operand already available".
  localparam logic [ROB_TAG_W-1:0] ROB_TAG_NONE = '0;

  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT_MEM
  } lsb_state_e;

  typedef struct packed {
    logic                 is_store;
    logic [2:0]           funct3;
    logic [ROB_TAG_W-1:0] rob_id;
    logic [ROB_TAG_W-1:0] dep1;
    logic [XLEN-1:0]      val1;
    logic [ROB_TAG_W-1:0] dep2;
    logic [XLEN-1:0]      val2;
    logic [XLEN-1:0]      imm;
  } lsb_entry_t;

  // Access size is carried directly in the low funct3 bits for both loads and stores.
  function automatic logic [1:0] size_of(input logic [2:0] funct3);
    return funct3[1:0];
  endfunction

endpackage

// File: rtl/load_store_buffer_if.sv
// Memory request bus between the load/store buffer (master) and memory (slave).
// Ports: mem_req/mem_we/mem_addr/mem_wdata/mem_size from master,
//        mem_done/mem_rdata from slave.
interface load_store_buffer_if;

  logic                                  mem_req;
  logic                                  mem_we;
  logic [load_store_buffer_pkg::XLEN-1:0] mem_addr;
  logic [load_store_buffer_pkg::XLEN-1:0] mem_wdata;
  logic [1:0]                            mem_size;
  logic                                  mem_done;
  logic [load_store_buffer_pkg::XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_size,
    input  mem_done, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_size,
    output mem_done, mem_rdata
  );

endinterface

// File: rtl/load_store_buffer_load_extend.sv
// Combinational load data extension.
// Ports: funct3 (load type), raw (LSB-aligned memory data), result (register value).
module load_store_buffer_load_extend
  import load_store_buffer_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] result
);

  always_comb begin
    result = raw;
    unique case (funct3)
      F3_LB:   result = {{24{raw[7]}}, raw[7:0]};
      F3_LH:   result = {{16{raw[15]}}, raw[15:0]};
      F3_LBU:  result = {24'd0, raw[7:0]};
      F3_LHU:  result = {16'd0, raw[15:0]};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/load_store_buffer.sv
// In-order load/store queue beside the ROB. Entries capture operands by snooping
// the ALU CDB and the loopback of this block's own CDB, and the head entry issues
// to memory only once the ROB head names it, so all accesses are non-speculative.
// Ports: clk_in/rst_in/rdy_in/clear_in control; lsb_* dispatch and lsb_full;
//        cdb_* and cdb_ls_in_* snoop buses; store_ready/work_rob_id ROB head;
//        mem (memory bus master); cdb_ls_* result broadcast.
module load_store_buffer
  import load_store_buffer_pkg::*;
#(
  parameter int unsigned LSB_SIZE = 8,
  parameter int unsigned IDX_W    = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear_in,
  input  logic                 lsb_valid,
  input  logic                 lsb_is_store,
  input  logic [2:0]           lsb_funct3,
  input  logic [ROB_TAG_W-1:0] lsb_rob_id,
  input  logic [ROB_TAG_W-1:0] lsb_dep1,
  input  logic [XLEN-1:0]      lsb_val1,
  input  logic [ROB_TAG_W-1:0] lsb_dep2,
  input  logic [XLEN-1:0]      lsb_val2,
  input  logic [XLEN-1:0]      lsb_imm,
  output logic                 lsb_full,
  input  logic                 cdb_ready,
  input  logic [ROB_TAG_W-1:0] cdb_rob_id,
  input  logic [XLEN-1:0]      cdb_value,
  input  logic                 cdb_ls_in_ready,
  input  logic [ROB_TAG_W-1:0] cdb_ls_in_rob_id,
  input  logic [XLEN-1:0]      cdb_ls_in_value,
  input  logic                 store_ready,
  input  logic [ROB_TAG_W-1:0] work_rob_id,
  load_store_buffer_if.master  mem,
  output logic                 cdb_ls_ready,
  output logic [ROB_TAG_W-1:0] cdb_ls_rob_id,
  output logic [XLEN-1:0]      cdb_ls_value
);

  localparam int unsigned CNT_W = IDX_W + 1;

  lsb_entry_t           entries_q [LSB_SIZE];
  lsb_entry_t           entries_d [LSB_SIZE];
  logic [LSB_SIZE-1:0]  valid_q, valid_d;
  logic [IDX_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  lsb_state_e           state_q, state_d;
  logic                 suppress_q, suppress_d;
  logic                 full_q, full_d;
  logic                 mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [XLEN-1:0]      mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [1:0]           mem_size_q, mem_size_d;
  logic                 cdb_ls_ready_q, cdb_ls_ready_d;
  logic [ROB_TAG_W-1:0] cdb_ls_rob_id_q, cdb_ls_rob_id_d;
  logic [XLEN-1:0]      cdb_ls_value_q, cdb_ls_value_d;
  logic                 inflight_store_q, inflight_store_d;
  logic [2:0]           inflight_f3_q, inflight_f3_d;
  logic [ROB_TAG_W-1:0] inflight_rob_q, inflight_rob_d;

  lsb_entry_t           head_ent;
  lsb_entry_t           new_ent;
  logic                 issue_ok, retire, accept;
  logic [XLEN-1:0]      load_value;

  load_store_buffer_load_extend u_load_extend (
    .funct3 (inflight_f3_q),
    .raw    (mem.mem_rdata),
    .result (load_value)
  );

  // Resolve one operand against both CDB buses; a hit returns the value with tag cleared.
  function automatic logic [ROB_TAG_W+XLEN-1:0] capture(
    input logic [ROB_TAG_W-1:0] dep,
    input logic [XLEN-1:0]      val
  );
    if (dep != ROB_TAG_NONE && cdb_ready && dep == cdb_rob_id) begin
      return {ROB_TAG_NONE, cdb_value};
    end
    if (dep != ROB_TAG_NONE && cdb_ls_in_ready && dep == cdb_ls_in_rob_id) begin
      return {ROB_TAG_NONE, cdb_ls_in_value};
    end
    return {dep, val};
  endfunction

  // Next-state: snoop, issue, completion, dispatch and flush.
  always_comb begin
    entries_d        = entries_q;
    valid_d          = valid_q;
    head_d           = head_q;
    tail_d           = tail_q;
    count_d          = count_q;
    state_d          = state_q;
    suppress_d       = suppress_q;
    full_d           = full_q;
    mem_req_d        = mem_req_q;
    mem_we_d         = mem_we_q;
    mem_addr_d       = mem_addr_q;
    mem_wdata_d      = mem_wdata_q;
    mem_size_d       = mem_size_q;
    cdb_ls_ready_d   = cdb_ls_ready_q;
    cdb_ls_rob_id_d  = cdb_ls_rob_id_q;
    cdb_ls_value_d   = cdb_ls_value_q;
    inflight_store_d = inflight_store_q;
    inflight_f3_d    = inflight_f3_q;
    inflight_rob_d   = inflight_rob_q;
    retire           = 1'b0;
    accept           = 1'b0;
    new_ent          = '0;
    head_ent         = entries_q[head_q];
    issue_ok         = valid_q[head_q] && (head_ent.dep1 == ROB_TAG_NONE) &&
                       (!head_ent.is_store || head_ent.dep2 == ROB_TAG_NONE) &&
                       store_ready && (work_rob_id == head_ent.rob_id) &&
                       (state_q == ST_IDLE);

    if (rdy_in) begin
      cdb_ls_ready_d = 1'b0;

      // A flushed in-flight access still completes, but its broadcast is dropped.
      if (state_q == ST_WAIT_MEM && mem.mem_done) begin
        state_d    = ST_IDLE;
        mem_req_d  = 1'b0;
        suppress_d = 1'b0;
        if (!suppress_q && !clear_in) begin
          retire          = 1'b1;
          cdb_ls_ready_d  = 1'b1;
          cdb_ls_rob_id_d = inflight_rob_q;
          cdb_ls_value_d  = inflight_store_q ? '0 : load_value;
        end
      end else if (state_q == ST_WAIT_MEM && clear_in) begin
        suppress_d = 1'b1;
      end

      if (clear_in) begin
        valid_d = '0;
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        for (int i = 0; i < int'(LSB_SIZE); i++) begin
          if (valid_q[i]) begin
            {entries_d[i].dep1, entries_d[i].val1} = capture(entries_q[i].dep1, entries_q[i].val1);
            {entries_d[i].dep2, entries_d[i].val2} = capture(entries_q[i].dep2, entries_q[i].val2);
          end
        end

        if (issue_ok) begin
          state_d          = ST_WAIT_MEM;
          mem_req_d        = 1'b1;
          mem_we_d         = head_ent.is_store;
          mem_addr_d       = head_ent.val1 + head_ent.imm;
          mem_wdata_d      = head_ent.val2;
          mem_size_d       = size_of(head_ent.funct3);
          inflight_store_d = head_ent.is_store;
          inflight_f3_d    = head_ent.funct3;
          inflight_rob_d   = head_ent.rob_id;
        end

        if (retire) begin
          valid_d[head_q] = 1'b0;
          head_d          = head_q + IDX_W'(1);
        end

        // A dispatch is dropped only when no slot is free.
        accept = lsb_valid && (count_q < CNT_W'(LSB_SIZE));
        if (accept) begin
          new_ent.is_store = lsb_is_store;
          new_ent.funct3   = lsb_funct3;
          new_ent.rob_id   = lsb_rob_id;
          new_ent.imm      = lsb_imm;
          {new_ent.dep1, new_ent.val1} = capture(lsb_dep1, lsb_val1);
          {new_ent.dep2, new_ent.val2} = capture(lsb_dep2, lsb_val2);
          entries_d[tail_q] = new_ent;
          valid_d[tail_q]   = 1'b1;
          tail_d            = tail_q + IDX_W'(1);
        end

        count_d = count_q + CNT_W'(accept) - CNT_W'(retire);
      end

      full_d = (count_d >= CNT_W'(LSB_SIZE - 1));
    end
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < int'(LSB_SIZE); i++) begin
        entries_q[i] <= '0;
      end
      valid_q          <= '0;
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      state_q          <= ST_IDLE;
      suppress_q       <= 1'b0;
      full_q           <= 1'b0;
      mem_req_q        <= 1'b0;
      mem_we_q         <= 1'b0;
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
      mem_size_q       <= '0;
      cdb_ls_ready_q   <= 1'b0;
      cdb_ls_rob_id_q  <= '0;
      cdb_ls_value_q   <= '0;
      inflight_store_q <= 1'b0;
      inflight_f3_q    <= '0;
      inflight_rob_q   <= '0;
    end else begin
      entries_q        <= entries_d;
      valid_q          <= valid_d;
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      state_q          <= state_d;
      suppress_q       <= suppress_d;
      full_q           <= full_d;
      mem_req_q        <= mem_req_d;
      mem_we_q         <= mem_we_d;
      mem_addr_q       <= mem_addr_d;
      mem_wdata_q      <= mem_wdata_d;
      mem_size_q       <= mem_size_d;
      cdb_ls_ready_q   <= cdb_ls_ready_d;
      cdb_ls_rob_id_q  <= cdb_ls_rob_id_d;
      cdb_ls_value_q   <= cdb_ls_value_d;
      inflight_store_q <= inflight_store_d;
      inflight_f3_q    <= inflight_f3_d;
      inflight_rob_q   <= inflight_rob_d;
    end
  end

  assign lsb_full      = full_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_size  = mem_size_q;
  assign cdb_ls_ready  = cdb_ls_ready_q;
  assign cdb_ls_rob_id = cdb_ls_rob_id_q;
  assign cdb_ls_value  = cdb_ls_value_q;

endmodule

// File: tb/tb_load_store_buffer.sv
// Self-checking bench for load_store_buffer: bench acts as dispatcher, ROB head
// and memory; expected broadcasts are queued and compared as they appear.
module tb_load_store_buffer;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear_in;
  logic        lsb_valid, lsb_is_store;
  logic [2:0]  lsb_funct3;
  logic [4:0]  lsb_rob_id, lsb_dep1, lsb_dep2;
  logic [31:0] lsb_val1, lsb_val2, lsb_imm;
  logic        lsb_full;
  logic        cdb_ready, cdb_ls_in_ready;
  logic [4:0]  cdb_rob_id, cdb_ls_in_rob_id;
  logic [31:0] cdb_value, cdb_ls_in_value;
  logic        store_ready;
  logic [4:0]  work_rob_id;
  logic        cdb_ls_ready;
  logic [4:0]  cdb_ls_rob_id;
  logic [31:0] cdb_ls_value;

  load_store_buffer_if mem_if ();

  load_store_buffer dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .clear_in         (clear_in),
    .lsb_valid        (lsb_valid),
    .lsb_is_store     (lsb_is_store),
    .lsb_funct3       (lsb_funct3),
    .lsb_rob_id       (lsb_rob_id),
    .lsb_dep1         (lsb_dep1),
    .lsb_val1         (lsb_val1),
    .lsb_dep2         (lsb_dep2),
    .lsb_val2         (lsb_val2),
    .lsb_imm          (lsb_imm),
    .lsb_full         (lsb_full),
    .cdb_ready        (cdb_ready),
    .cdb_rob_id       (cdb_rob_id),
    .cdb_value        (cdb_value),
    .cdb_ls_in_ready  (cdb_ls_in_ready),
    .cdb_ls_in_rob_id (cdb_ls_in_rob_id),
    .cdb_ls_in_value  (cdb_ls_in_value),
    .store_ready      (store_ready),
    .work_rob_id      (work_rob_id),
    .mem              (mem_if),
    .cdb_ls_ready     (cdb_ls_ready),
    .cdb_ls_rob_id    (cdb_ls_rob_id),
    .cdb_ls_value     (cdb_ls_value)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [4:0]  rob;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference load extension.
  function automatic logic [31:0] ext_model(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return {{24{d[7]}}, d[7:0]};
      3'b001:  return {{16{d[15]}}, d[15:0]};
      3'b100:  return {24'd0, d[7:0]};
      3'b101:  return {16'd0, d[15:0]};
      default: return d;
    endcase
  endfunction

  // Broadcast monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk_in) begin
    if (!rst_in && cdb_ls_ready) begin
      if (sb.size() == 0) begin
        check("cdb_unexpected", 32'(cdb_ls_rob_id), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("cdb_rob", 32'(cdb_ls_rob_id), 32'(e.rob));
        check("cdb_val", cdb_ls_value, e.val);
      end
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_in);
  endtask

  task automatic dispatch(input logic st, input logic [2:0] f3, input logic [4:0] rob,
                          input logic [4:0] d1, input logic [31:0] v1,
                          input logic [4:0] d2, input logic [31:0] v2, input logic [31:0] imm);
    lsb_valid = 1'b1; lsb_is_store = st; lsb_funct3 = f3; lsb_rob_id = rob;
    lsb_dep1 = d1; lsb_val1 = v1; lsb_dep2 = d2; lsb_val2 = v2; lsb_imm = imm;
    @(negedge clk_in);
    lsb_valid = 1'b0;
  endtask

  task automatic wait_req(input string tag, input logic [31:0] addr, input logic we,
                          input logic [1:0] size, input logic [31:0] wdata);
    int n = 0;
    while (!mem_if.mem_req && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    if (!mem_if.mem_req) begin
      check({tag, "_timeout"}, 32'(mem_if.mem_req), 32'd1);
    end else begin
      check({tag, "_addr"}, mem_if.mem_addr, addr);
      check({tag, "_we"}, 32'(mem_if.mem_we), 32'(we));
      check({tag, "_size"}, 32'(mem_if.mem_size), 32'(size));
      check({tag, "_wdata"}, mem_if.mem_wdata, wdata);
    end
  endtask

  task automatic finish_mem(input logic [31:0] rdata, input bit expect_bc,
                            input logic [4:0] rob, input logic [31:0] val);
    exp_t e;
    if (expect_bc) begin
      e.rob = rob; e.val = val;
      sb.push_back(e);
    end
    mem_if.mem_done = 1'b1; mem_if.mem_rdata = rdata;
    @(negedge clk_in);
    mem_if.mem_done = 1'b0;
    check("req_drop", 32'(mem_if.mem_req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x00000000 expected 0x00000001");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0;
    lsb_valid = 1'b0; lsb_is_store = 1'b0; lsb_funct3 = '0; lsb_rob_id = '0;
    lsb_dep1 = '0; lsb_dep2 = '0; lsb_val1 = '0; lsb_val2 = '0; lsb_imm = '0;
    cdb_ready = 1'b0; cdb_rob_id = '0; cdb_value = '0;
    cdb_ls_in_ready = 1'b0; cdb_ls_in_rob_id = '0; cdb_ls_in_value = '0;
    store_ready = 1'b0; work_rob_id = '0;
    mem_if.mem_done = 1'b0; mem_if.mem_rdata = '0;
    cyc(3);
    rst_in = 1'b0;
    cyc(1);
    check("rst_req", 32'(mem_if.mem_req), 32'd0);
    check("rst_full", 32'(lsb_full), 32'd0);
    check("rst_cdb", 32'(cdb_ls_ready), 32'd0);
    check("rst_addr", mem_if.mem_addr, 32'd0);

    // 1: LW
    store_ready = 1'b1; work_rob_id = 5'd3;
    dispatch(1'b0, 3'b010, 5'd3, 5'd0, 32'h1000, 5'd0, 32'h0, 32'd8);
    wait_req("lw", 32'h1008, 1'b0, 2'd2, 32'h0);
    finish_mem(32'hDEADBEEF, 1, 5'd3, 32'hDEADBEEF);
    cyc(1);

    // 2: byte/half loads with sign and zero extension
    work_rob_id = 5'd0;
    dispatch(1'b0, 3'b000, 5'd6, 5'd0, 32'h2000, 5'd0, 32'h0, 32'hFFFF_FFFF);
    dispatch(1'b0, 3'b100, 5'd7, 5'd0, 32'h2000, 5'd0, 32'h0, 32'd1);
    dispatch(1'b0, 3'b001, 5'd8, 5'd0, 32'h2000, 5'd0, 32'h0, 32'd2);
    dispatch(1'b0, 3'b101, 5'd1, 5'd0, 32'h2000, 5'd0, 32'h0, 32'd4);
    work_rob_id = 5'd6;
    wait_req("lb", 32'h1FFF, 1'b0, 2'd0, 32'h0);
    finish_mem(32'h0000_0080, 1, 5'd6, ext_model(3'b000, 32'h80));
    work_rob_id = 5'd7;
    wait_req("lbu", 32'h2001, 1'b0, 2'd0, 32'h0);
    finish_mem(32'h0000_0080, 1, 5'd7, ext_model(3'b100, 32'h80));
    work_rob_id = 5'd8;
    wait_req("lh", 32'h2002, 1'b0, 2'd1, 32'h0);
    finish_mem(32'h1234_8000, 1, 5'd8, ext_model(3'b001, 32'h1234_8000));
    work_rob_id = 5'd1;
    wait_req("lhu", 32'h2004, 1'b0, 2'd1, 32'h0);
    finish_mem(32'h1234_8000, 1, 5'd1, ext_model(3'b101, 32'h1234_8000));
    cyc(1);

    // 3: store waiting on data tag, then same-cycle bypass on dispatch
    work_rob_id = 5'd5;
    dispatch(1'b1, 3'b010, 5'd5, 5'd0, 32'h500, 5'd4, 32'hBAD, 32'd4);
    cyc(3);
    check("sw_blocked", 32'(mem_if.mem_req), 32'd0);
    cdb_ready = 1'b1; cdb_rob_id = 5'd4; cdb_value = 32'h55;
    cyc(1);
    cdb_ready = 1'b0;
    wait_req("sw", 32'h504, 1'b1, 2'd2, 32'h55);
    finish_mem(32'h1234_5678, 1, 5'd5, 32'h0);
    work_rob_id = 5'd9;
    cdb_ls_in_ready = 1'b1; cdb_ls_in_rob_id = 5'd8; cdb_ls_in_value = 32'h3000;
    dispatch(1'b1, 3'b000, 5'd9, 5'd8, 32'h0, 5'd0, 32'h1AB, 32'd4);
    cdb_ls_in_ready = 1'b0;
    wait_req("sb_bypass", 32'h3004, 1'b1, 2'd0, 32'h1AB);
    finish_mem(32'h0, 1, 5'd9, 32'h0);
    cyc(1);

    // 4: fill to LSB_SIZE-1, then retire and dispatch in the same cycle
    work_rob_id = 5'd0;
    for (int i = 0; i < 7; i++) begin
      dispatch(1'b0, 3'b010, 5'(10 + i), 5'd0, 32'(32'h100 * i), 5'd0, 32'h0, 32'd0);
      if (i == 5) check("full_at6", 32'(lsb_full), 32'd0);
    end
    check("full_at7", 32'(lsb_full), 32'd1);
    work_rob_id = 5'd10;
    wait_req("fill10", 32'h0, 1'b0, 2'd2, 32'h0);
    lsb_valid = 1'b1; lsb_is_store = 1'b0; lsb_funct3 = 3'b010; lsb_rob_id = 5'd17;
    lsb_dep1 = '0; lsb_val1 = 32'h700; lsb_dep2 = '0; lsb_val2 = '0; lsb_imm = 32'd0;
    finish_mem(32'hA000_000A, 1, 5'd10, 32'hA000_000A);
    lsb_valid = 1'b0;
    check("full_swap", 32'(lsb_full), 32'd1);
    for (int r = 11; r <= 17; r++) begin
      work_rob_id = 5'(r);
      wait_req("drain", 32'(32'h100 * (r - 10)), 1'b0, 2'd2, 32'h0);
      finish_mem(32'hA000_0000 | 32'(r), 1, 5'(r), 32'hA000_0000 | 32'(r));
      if (r == 11) check("full_after_retire", 32'(lsb_full), 32'd0);
    end
    cyc(1);

    // 5: flush while a load is in flight
    work_rob_id = 5'd0;
    dispatch(1'b0, 3'b010, 5'd20, 5'd0, 32'h700, 5'd0, 32'h0, 32'd0);
    dispatch(1'b0, 3'b010, 5'd21, 5'd0, 32'h800, 5'd0, 32'h0, 32'd0);
    work_rob_id = 5'd20;
    wait_req("clr", 32'h700, 1'b0, 2'd2, 32'h0);
    clear_in = 1'b1;
    dispatch(1'b0, 3'b010, 5'd22, 5'd0, 32'h900, 5'd0, 32'h0, 32'd0);
    clear_in = 1'b0;
    work_rob_id = 5'd21;
    check("clr_req_hold", 32'(mem_if.mem_req), 32'd1);
    cyc(2);
    check("clr_req_hold2", 32'(mem_if.mem_req), 32'd1);
    finish_mem(32'h1111_1111, 0, 5'd0, 32'h0);
    cyc(2);
    check("clr_no_issue", 32'(mem_if.mem_req), 32'd0);
    work_rob_id = 5'd0;
    for (int i = 0; i < 7; i++) begin
      dispatch(1'b0, 3'b010, 5'(23 + i), 5'd0, 32'h0, 5'd0, 32'h0, 32'd0);
      if (i == 5) check("clr_cnt6", 32'(lsb_full), 32'd0);
    end
    check("clr_cnt7", 32'(lsb_full), 32'd1);
    clear_in = 1'b1;
    cyc(1);
    clear_in = 1'b0;
    check("clr_idle_full", 32'(lsb_full), 32'd0);
    work_rob_id = 5'd30;
    dispatch(1'b0, 3'b010, 5'd30, 5'd0, 32'hC00, 5'd0, 32'h0, 32'd12);
    wait_req("post_clr", 32'hC0C, 1'b0, 2'd2, 32'h0);
    finish_mem(32'h0BAD_F00D, 1, 5'd30, 32'h0BAD_F00D);
    cyc(1);

    // 6: pause during dispatch, snoop and memory completion
    work_rob_id = 5'd25;
    dispatch(1'b0, 3'b010, 5'd25, 5'd24, 32'h0, 5'd0, 32'h0, 32'h10);
    rdy_in = 1'b0;
    lsb_valid = 1'b1; lsb_rob_id = 5'd26; lsb_dep1 = 5'd0; lsb_val1 = 32'hF00;
    cdb_ready = 1'b1; cdb_rob_id = 5'd24; cdb_value = 32'h4000;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("pause_req", 32'(mem_if.mem_req), 32'd0);
    end
    rdy_in = 1'b1; lsb_valid = 1'b0; cdb_ready = 1'b0;
    cyc(2);
    check("pause_no_snoop", 32'(mem_if.mem_req), 32'd0);
    cdb_ready = 1'b1;
    cyc(1);
    cdb_ready = 1'b0;
    wait_req("pause_ld", 32'h4010, 1'b0, 2'd2, 32'h0);
    rdy_in = 1'b0; mem_if.mem_done = 1'b1; mem_if.mem_rdata = 32'h9999_9999;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("pause_hold_req", 32'(mem_if.mem_req), 32'd1);
    end
    rdy_in = 1'b1; mem_if.mem_done = 1'b0;
    finish_mem(32'h7777_0001, 1, 5'd25, 32'h7777_0001);
    work_rob_id = 5'd26;
    cyc(4);
    check("pause_no_disp", 32'(mem_if.mem_req), 32'd0);
    check("pause_full", 32'(lsb_full), 32'd0);

    cyc(3);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
